// File: rtl/entropy_conditioner.sv
// Health-tested (RCT + APT), von Neumann debiased entropy front end with a small bit FIFO.
// Optional macro ENTROPY_DEBIAS_BYPASS_EN adds a debias_bypass input that pushes raw bits directly.
module entropy_conditioner #(
    parameter int FIFO_DEPTH = 8,
    parameter int RCT_CUTOFF = 32,
    parameter int APT_WINDOW = 1024,
    parameter int APT_CUTOFF = 840
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic                        raw_bit,
    input  logic                        raw_valid,
    input  logic                        trng_next,
`ifdef ENTROPY_DEBIAS_BYPASS_EN
    input  logic                        debias_bypass,
`endif
    input  logic                        clear_fail,
    output logic                        trng_bit,
    output logic                        trng_valid,
    output logic                        health_fail,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int RW = $clog2(RCT_CUTOFF) + 1;
    localparam int AW = $clog2(APT_WINDOW) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [RW-1:0] RCT_LIM  = RW'(RCT_CUTOFF);
    localparam logic [AW-1:0] APT_WIN  = AW'(APT_WINDOW);
    localparam logic [AW-1:0] APT_LIM  = AW'(APT_CUTOFF);

    typedef enum logic [1:0] {ST_WARMUP, ST_RUN, ST_FAIL} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rct_cnt_q, rct_cnt_d;
    logic          rct_prev_q, rct_prev_d;
    logic [AW-1:0] apt_cnt_q, apt_cnt_d;
    logic [AW-1:0] apt_pos_q, apt_pos_d;
    logic          apt_ref_q, apt_ref_d;
    logic          pair_full_q, pair_full_d;
    logic          pair_first_q, pair_first_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          trng_bit_q, trng_bit_d;
    logic          trng_valid_q, trng_valid_d;
    logic          health_fail_q, health_fail_d;
    logic          mem_q [FIFO_DEPTH];

    logic push_req, push_bit, pop, wr_en, fail_det, pair_clr, bypass_on;
`ifdef ENTROPY_DEBIAS_BYPASS_EN
    logic bypass_q, bypass_d;
`endif

    always_comb begin
        state_d       = state_q;
        rct_cnt_d     = rct_cnt_q;
        rct_prev_d    = rct_prev_q;
        apt_cnt_d     = apt_cnt_q;
        apt_pos_d     = apt_pos_q;
        apt_ref_d     = apt_ref_q;
        pair_full_d   = pair_full_q;
        pair_first_d  = pair_first_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        trng_bit_d    = trng_bit_q;
        trng_valid_d  = 1'b0;
        health_fail_d = health_fail_q;
        push_req      = 1'b0;
        push_bit      = 1'b0;
        pop           = 1'b0;
        fail_det      = 1'b0;
        pair_clr      = 1'b0;
        bypass_on     = 1'b0;
`ifdef ENTROPY_DEBIAS_BYPASS_EN
        bypass_d      = bypass_q;
`endif
        if (en) begin
`ifdef ENTROPY_DEBIAS_BYPASS_EN
            bypass_d  = debias_bypass;
            bypass_on = debias_bypass;
            pair_clr  = (debias_bypass != bypass_q);
            if (pair_clr) pair_full_d = 1'b0;
`endif
            pop = (state_q == ST_RUN) && (count_q != '0) && trng_next;
            if (state_q == ST_FAIL) begin
                if (clear_fail) begin
                    state_d       = ST_WARMUP;
                    health_fail_d = 1'b0;
                    rct_cnt_d     = '0;
                    apt_cnt_d     = '0;
                    apt_pos_d     = '0;
                    pair_full_d   = 1'b0;
                end
            end else if (raw_valid) begin
                // rct_cnt of zero marks "no previous bit" after reset or clear
                if (rct_cnt_q != '0 && raw_bit == rct_prev_q) rct_cnt_d = rct_cnt_q + 1'b1;
                else                                          rct_cnt_d = RW'(1);
                rct_prev_d = raw_bit;
                if (apt_pos_q == '0 || apt_pos_q == APT_WIN) begin
                    apt_ref_d = raw_bit;
                    apt_cnt_d = AW'(1);
                    apt_pos_d = AW'(1);
                end else begin
                    apt_pos_d = apt_pos_q + 1'b1;
                    if (raw_bit == apt_ref_q) apt_cnt_d = apt_cnt_q + 1'b1;
                end
                fail_det = (rct_cnt_d >= RCT_LIM) || (apt_cnt_d >= APT_LIM);
                if (state_q == ST_WARMUP) begin
                    // warm-up spans exactly the first APT window after reset or clear
                    if (!fail_det && apt_pos_d == APT_WIN) begin
                        state_d     = ST_RUN;
                        pair_full_d = 1'b0;
                    end
                end else if (bypass_on) begin
                    push_req    = 1'b1;
                    push_bit    = raw_bit;
                    pair_full_d = 1'b0;
                end else if (pair_full_q && !pair_clr) begin
                    pair_full_d = 1'b0;
                    if (pair_first_q != raw_bit) begin
                        push_req = 1'b1;
                        push_bit = pair_first_q;
                    end
                end else begin
                    pair_full_d  = 1'b1;
                    pair_first_d = raw_bit;
                end
            end
        end
        if (pop) begin
            trng_bit_d   = mem_q[rd_ptr_q];
            trng_valid_d = 1'b1;
            rd_ptr_d     = rd_ptr_q + 1'b1;
        end
        wr_en = push_req && ((count_q != FULL_LVL) || pop);
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        count_d = count_q + LW'(wr_en) - LW'(pop);
        // a pop in the failing cycle still delivers; the flush lands with FAIL
        if (fail_det) begin
            state_d       = ST_FAIL;
            health_fail_d = 1'b1;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            pair_full_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_WARMUP;
            rct_cnt_q     <= '0;
            rct_prev_q    <= 1'b0;
            apt_cnt_q     <= '0;
            apt_pos_q     <= '0;
            apt_ref_q     <= 1'b0;
            pair_full_q   <= 1'b0;
            pair_first_q  <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            trng_bit_q    <= 1'b0;
            trng_valid_q  <= 1'b0;
            health_fail_q <= 1'b0;
`ifdef ENTROPY_DEBIAS_BYPASS_EN
            bypass_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rct_cnt_q     <= rct_cnt_d;
            rct_prev_q    <= rct_prev_d;
            apt_cnt_q     <= apt_cnt_d;
            apt_pos_q     <= apt_pos_d;
            apt_ref_q     <= apt_ref_d;
            pair_full_q   <= pair_full_d;
            pair_first_q  <= pair_first_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            trng_bit_q    <= trng_bit_d;
            trng_valid_q  <= trng_valid_d;
            health_fail_q <= health_fail_d;
`ifdef ENTROPY_DEBIAS_BYPASS_EN
            bypass_q      <= bypass_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_bit;
    end

    assign trng_bit    = trng_bit_q;
    assign trng_valid  = trng_valid_q;
    assign health_fail = health_fail_q;
    assign fifo_level  = count_q;
endmodule

// File: tb/tb_entropy_conditioner.sv
// Bench for entropy_conditioner: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based behavioural model.
module tb_entropy_conditioner;
    localparam int DEPTH = 8;
    localparam int RCT_C = 8;
    localparam int WIN   = 16;
    localparam int APT_C = 13;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       en = 1'b1;
    logic       raw_bit = 1'b0;
    logic       raw_valid = 1'b0;
    logic       trng_next = 1'b0;
    logic       clear_fail = 1'b0;
    logic       trng_bit, trng_valid, health_fail;
    logic [3:0] fifo_level;

    int pass_cnt = 0;
    int check_cnt = 0;

    entropy_conditioner #(
        .FIFO_DEPTH(DEPTH), .RCT_CUTOFF(RCT_C), .APT_WINDOW(WIN), .APT_CUTOFF(APT_C)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .raw_bit(raw_bit), .raw_valid(raw_valid),
        .trng_next(trng_next), .clear_fail(clear_fail), .trng_bit(trng_bit),
        .trng_valid(trng_valid), .health_fail(health_fail), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        check_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: 0 = warm-up, 1 = run, 2 = failed
    int m_state = 0;
    bit m_bit = 1'b0;
    bit m_valid = 1'b0;
    bit fifo_m[$];
    bit win[$];
    bit pair[$];
    int run_len = 0;
    int warm_cnt = 0;
    bit last_bit = 1'b0;
    bit have_last = 1'b0;
    bit m_pop, m_push, m_pbit, m_fail;
    int same;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_bit = 0; m_valid = 0;
            fifo_m.delete(); win.delete(); pair.delete();
            run_len = 0; warm_cnt = 0; have_last = 0;
        end else begin
            m_valid = 0; m_push = 0; m_pbit = 0; m_fail = 0; m_pop = 0;
            if (en) begin
                m_pop = (m_state == 1) && (fifo_m.size() > 0) && trng_next;
                if (m_state == 2) begin
                    if (clear_fail) begin
                        m_state = 0; win.delete(); pair.delete();
                        run_len = 0; warm_cnt = 0; have_last = 0;
                    end
                end else if (raw_valid) begin
                    run_len = (have_last && raw_bit == last_bit) ? run_len + 1 : 1;
                    last_bit = raw_bit; have_last = 1;
                    if (win.size() == WIN) win.delete();
                    win.push_back(raw_bit);
                    same = 0;
                    foreach (win[i]) if (win[i] == win[0]) same++;
                    m_fail = (run_len >= RCT_C) || (same >= APT_C);
                    if (m_state == 0) begin
                        warm_cnt++;
                        if (!m_fail && warm_cnt == WIN) begin m_state = 1; pair.delete(); end
                    end else begin
                        pair.push_back(raw_bit);
                        if (pair.size() == 2) begin
                            if (pair[0] != pair[1]) begin m_push = 1; m_pbit = pair[0]; end
                            pair.delete();
                        end
                    end
                end
                if (m_pop) begin m_bit = fifo_m.pop_front(); m_valid = 1; end
                if (m_push && fifo_m.size() < DEPTH) fifo_m.push_back(m_pbit);
                if (m_fail) begin m_state = 2; fifo_m.delete(); pair.delete(); end
            end
        end
    end

    always @(negedge clk) begin
        chk("trng_valid", int'(trng_valid), int'(m_valid));
        chk("trng_bit", int'(trng_bit), int'(m_bit));
        chk("health_fail", int'(health_fail), (m_state == 2) ? 1 : 0);
        chk("fifo_level", int'(fifo_level), fifo_m.size());
    end

    task automatic step(input logic v, input logic b, input logic nx, input logic clr);
        @(negedge clk);
        raw_valid = v; raw_bit = b; trng_next = nx; clear_fail = clr;
        @(posedge clk);
        #1;
    endtask

    bit b;
    bit lastb;
    bit exp_q[$];
    logic [9:0] pbits;
    logic [14:0] aptbits;

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        chk("rst_bit", int'(trng_bit), 0);
        chk("rst_valid", int'(trng_valid), 0);
        chk("rst_fail", int'(health_fail), 0);
        chk("rst_level", int'(fifo_level), 0);

        // warm-up then debias
        for (int i = 0; i < 16; i++) step(1, i[0], 0, 0);
        chk("warm_no_push", int'(fifo_level), 0);
        pbits = 10'b10_01_11_00_10;
        for (int i = 9; i >= 0; i--) step(1, pbits[i], 0, 0);
        chk("debias_level", int'(fifo_level), 3);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            chk("drain_valid", int'(trng_valid), 1);
            chk("drain_bit", int'(trng_bit), (i != 1) ? 1 : 0);
        end
        chk("drain_level", int'(fifo_level), 0);
        step(0, 0, 0, 0);
        chk("idle_valid", int'(trng_valid), 0);
        chk("hold_bit", int'(trng_bit), 1);

        // RCT failure with bits in the FIFO
        step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
        chk("pre_rct_level", int'(fifo_level), 2);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 0);
            if (i == 6) chk("rct_7_ok", int'(health_fail), 0);
        end
        chk("rct_fail", int'(health_fail), 1);
        chk("rct_flush", int'(fifo_level), 0);
        step(0, 0, 1, 0);
        chk("fail_no_valid", int'(trng_valid), 0);

        // clear, then APT failure during warm-up
        step(0, 0, 0, 1);
        chk("clear1", int'(health_fail), 0);
        aptbits = 15'b0000000_1_00000_1_0;
        for (int i = 14; i >= 0; i--) begin
            step(1, aptbits[i], 0, 0);
            if (i == 1) chk("apt_12_ok", int'(health_fail), 0);
        end
        chk("apt_fail", int'(health_fail), 1);

        // recovery: warm-up again, no pushes until the window completes
        step(0, 0, 0, 1);
        chk("clear2", int'(health_fail), 0);
        for (int i = 0; i < 16; i++) step(1, ~i[0], 0, 0);
        chk("rewarm_no_push", int'(fifo_level), 0);
        step(1, 1, 0, 0); step(1, 0, 0, 0);
        exp_q.push_back(1'b1);
        chk("resume_push", int'(fifo_level), 1);

        // fill, overflow drop, then push+pop while full
        for (int k = 0; k < 7; k++) begin
            b = 1'($urandom_range(0, 1));
            step(1, b, 0, 0); step(1, ~b, 0, 0);
            exp_q.push_back(b);
        end
        chk("full_level", int'(fifo_level), 8);
        b = 1'($urandom_range(0, 1));
        step(1, b, 0, 0); step(1, ~b, 0, 0);
        chk("drop_level", int'(fifo_level), 8);
        b = 1'($urandom_range(0, 1));
        step(1, b, 0, 0); step(1, ~b, 1, 0);
        chk("pp_level", int'(fifo_level), 8);
        chk("pp_valid", int'(trng_valid), 1);
        chk("pp_bit", int'(trng_bit), int'(exp_q.pop_front()));
        exp_q.push_back(b);
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 1, 0);
            lastb = exp_q.pop_front();
            chk("order_bit", int'(trng_bit), int'(lastb));
        end
        chk("part_level", int'(fifo_level), 2);

        // enable low freezes everything
        en = 1'b0;
        for (int k = 0; k < 4; k++) step(1, 1, 1, 0);
        chk("en0_level", int'(fifo_level), 2);
        chk("en0_valid", int'(trng_valid), 0);
        chk("en0_bit", int'(trng_bit), int'(lastb));
        en = 1'b1;
        step(0, 0, 1, 0);
        chk("en1_bit", int'(trng_bit), int'(exp_q.pop_front()));
        chk("en1_level", int'(fifo_level), 1);

        // asynchronous reset with no clock edge
        #1 reset_n = 1'b0;
        #1;
        chk("arst_bit", int'(trng_bit), 0);
        chk("arst_valid", int'(trng_valid), 0);
        chk("arst_fail", int'(health_fail), 0);
        chk("arst_level", int'(fifo_level), 0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 (((i / 500) % 2) == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 19) == 0));
        end
        en = 1'b1;
        step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
